// File: rtl/sme_job_feeder.sv
// Buffers one tagged host job (string + pattern), replays it into the SME and returns the result.
// Define SME_FEED_STATS_EN to add the stat_jobs / stat_matches counters.
module sme_job_feeder #(
    parameter int unsigned STR_MAX = 32,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned TIMEOUT = 511
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_type,
    input  logic [7:0]  in_data,
    output logic [7:0]  sme_chardata,
    output logic        sme_isstring,
    output logic        sme_ispattern,
    input  logic        sme_valid,
    input  logic        sme_match,
    input  logic [4:0]  sme_match_index,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_match,
    output logic [4:0]  res_index,
    output logic [1:0]  res_err
`ifdef SME_FEED_STATS_EN
    ,
    output logic [15:0] stat_jobs,
    output logic [15:0] stat_matches
`endif
);

    localparam int unsigned SIW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int unsigned PIW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int unsigned SCW = $clog2(STR_MAX + 1);
    localparam int unsigned PCW = $clog2(PAT_MAX + 1);

    localparam logic [SCW-1:0] STR_FULL  = SCW'(STR_MAX);
    localparam logic [PCW-1:0] PAT_FULL  = PCW'(PAT_MAX);
    localparam logic [8:0]     TMO_LIMIT = 9'(TIMEOUT);

    localparam logic [2:0] LOAD     = 3'd0;
    localparam logic [2:0] SEND_STR = 3'd1;
    localparam logic [2:0] SEND_PAT = 3'd2;
    localparam logic [2:0] WAIT     = 3'd3;
    localparam logic [2:0] RESULT   = 3'd4;

    localparam logic [1:0] TYPE_STR = 2'd0;
    localparam logic [1:0] TYPE_PAT = 2'd1;
    localparam logic [1:0] TYPE_EOJ = 2'd2;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_OVF   = 2'd1;
    localparam logic [1:0] ERR_EMPTY = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    logic [2:0]     state_q, state_d;
    logic [SCW-1:0] s_cnt_q, s_cnt_d;
    logic [PCW-1:0] p_cnt_q, p_cnt_d;
    logic [SIW-1:0] str_idx_q, str_idx_d;
    logic [PIW-1:0] pat_idx_q, pat_idx_d;
    logic [8:0]     tmo_cnt_q, tmo_cnt_d;
    logic           err_q, err_d;
    logic           str_loaded_q, str_loaded_d;

    logic           res_match_d;
    logic [4:0]     res_index_d;
    logic [1:0]     res_err_d;
    logic [7:0]     chardata_d;
    logic           isstring_d, ispattern_d;

    logic [7:0]     str_buf [STR_MAX];
    logic [7:0]     pat_buf [PAT_MAX];

    logic           accept, str_wr, pat_wr;

    assign in_ready = (state_q == LOAD);
    assign accept   = in_valid && in_ready;
    assign str_wr   = accept && (in_type == TYPE_STR) && (s_cnt_q != STR_FULL);
    assign pat_wr   = accept && (in_type == TYPE_PAT) && (p_cnt_q != PAT_FULL);

    always_ff @(posedge clk) begin
        if (str_wr) str_buf[s_cnt_q[SIW-1:0]] <= in_data;
        if (pat_wr) pat_buf[p_cnt_q[PIW-1:0]] <= in_data;
    end

    always_comb begin
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        p_cnt_d      = p_cnt_q;
        str_idx_d    = str_idx_q;
        pat_idx_d    = pat_idx_q;
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = err_q;
        str_loaded_d = str_loaded_q;
        res_match_d  = res_match;
        res_index_d  = res_index;
        res_err_d    = res_err;

        case (state_q)
            LOAD: begin
                if (accept) begin
                    case (in_type)
                        TYPE_STR: begin
                            if (str_wr) s_cnt_d = s_cnt_q + 1'b1;
                            else        err_d = 1'b1;
                        end
                        TYPE_PAT: begin
                            if (pat_wr) p_cnt_d = p_cnt_q + 1'b1;
                            else        pat_idx_d = pat_idx_q;
                            if (!pat_wr) err_d = 1'b1;
                        end
                        TYPE_EOJ: begin
                            str_idx_d = '0;
                            pat_idx_d = '0;
                            if (err_q) begin
                                state_d     = RESULT;
                                res_match_d = 1'b0;
                                res_index_d = '0;
                                res_err_d   = ERR_OVF;
                            end else if (p_cnt_q == '0 || (s_cnt_q == '0 && !str_loaded_q)) begin
                                state_d     = RESULT;
                                res_match_d = 1'b0;
                                res_index_d = '0;
                                res_err_d   = ERR_EMPTY;
                            end else if (s_cnt_q != '0) begin
                                state_d = SEND_STR;
                            end else begin
                                // SME still holds the string from the previous job
                                state_d = SEND_PAT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SEND_STR: begin
                if (SCW'(str_idx_q) + 1'b1 == s_cnt_q) begin
                    state_d      = SEND_PAT;
                    str_idx_d    = '0;
                    str_loaded_d = 1'b1;
                end else begin
                    str_idx_d = str_idx_q + 1'b1;
                end
            end
            SEND_PAT: begin
                if (PCW'(pat_idx_q) + 1'b1 == p_cnt_q) begin
                    state_d   = WAIT;
                    pat_idx_d = '0;
                    tmo_cnt_d = '0;
                end else begin
                    pat_idx_d = pat_idx_q + 1'b1;
                end
            end
            WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (sme_valid) begin
                    state_d     = RESULT;
                    res_match_d = sme_match;
                    res_index_d = sme_match_index;
                    res_err_d   = ERR_OK;
                end else if (tmo_cnt_q == TMO_LIMIT) begin
                    state_d      = RESULT;
                    res_match_d  = 1'b0;
                    res_index_d  = '0;
                    res_err_d    = ERR_TMO;
                    str_loaded_d = 1'b0;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = LOAD;
                    s_cnt_d = '0;
                    p_cnt_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // SME-side outputs are registered from the next state so they line up with the state itself
    always_comb begin
        chardata_d  = '0;
        isstring_d  = 1'b0;
        ispattern_d = 1'b0;
        if (state_d == SEND_STR) begin
            isstring_d = 1'b1;
            chardata_d = str_buf[str_idx_d];
        end else if (state_d == SEND_PAT) begin
            ispattern_d = 1'b1;
            chardata_d  = pat_buf[pat_idx_d];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= LOAD;
            s_cnt_q       <= '0;
            p_cnt_q       <= '0;
            str_idx_q     <= '0;
            pat_idx_q     <= '0;
            tmo_cnt_q     <= '0;
            err_q         <= 1'b0;
            str_loaded_q  <= 1'b0;
            sme_chardata  <= '0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            res_valid     <= 1'b0;
            res_match     <= 1'b0;
            res_index     <= '0;
            res_err       <= '0;
        end else begin
            state_q       <= state_d;
            s_cnt_q       <= s_cnt_d;
            p_cnt_q       <= p_cnt_d;
            str_idx_q     <= str_idx_d;
            pat_idx_q     <= pat_idx_d;
            tmo_cnt_q     <= tmo_cnt_d;
            err_q         <= err_d;
            str_loaded_q  <= str_loaded_d;
            sme_chardata  <= chardata_d;
            sme_isstring  <= isstring_d;
            sme_ispattern <= ispattern_d;
            res_valid     <= (state_d == RESULT);
            res_match     <= res_match_d;
            res_index     <= res_index_d;
            res_err       <= res_err_d;
        end
    end

`ifdef SME_FEED_STATS_EN
    logic job_done;
    assign job_done = (state_q == RESULT) && res_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_jobs    <= '0;
            stat_matches <= '0;
        end else if (job_done) begin
            if (stat_jobs != 16'hFFFF) stat_jobs <= stat_jobs + 16'd1;
            if (res_match && res_err == ERR_OK && stat_matches != 16'hFFFF) begin
                stat_matches <= stat_matches + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sme_job_feeder.sv
// Self-checking bench for sme_job_feeder: randomized host jobs against a job-level model
// plus a stub SME that answers from the bytes it actually received.
module tb_sme_job_feeder;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int TIMEOUT = 511;

    typedef logic [7:0] bytes_t[$];

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_type = 2'd0;
    logic [7:0] in_data = 8'd0;
    logic [7:0] sme_chardata;
    logic       sme_isstring;
    logic       sme_ispattern;
    logic       sme_valid = 1'b0;
    logic       sme_match = 1'b0;
    logic [4:0] sme_match_index = 5'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       res_match;
    logic [4:0] res_index;
    logic [1:0] res_err;
`ifdef SME_FEED_STATS_EN
    logic [15:0] stat_jobs;
    logic [15:0] stat_matches;
`endif

    int n_checks = 0;
    int n_fail = 0;

    bytes_t job_str, job_pat, model_str, sme_str;
    bit     model_loaded = 1'b0;
    int     model_jobs = 0;
    int     model_matches = 0;

    always #5 clk = ~clk;

    sme_job_feeder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_type         (in_type),
        .in_data         (in_data),
        .sme_chardata    (sme_chardata),
        .sme_isstring    (sme_isstring),
        .sme_ispattern   (sme_ispattern),
        .sme_valid       (sme_valid),
        .sme_match       (sme_match),
        .sme_match_index (sme_match_index),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_match       (res_match),
        .res_index       (res_index),
        .res_err         (res_err)
`ifdef SME_FEED_STATS_EN
        ,
        .stat_jobs       (stat_jobs),
        .stat_matches    (stat_matches)
`endif
    );

    // SME matching rules: '.' any char, leading '^' = word start, trailing '$' = word end
    function automatic logic [5:0] ref_match(input bytes_t s, input bytes_t p);
        int lo, hi, j, e;
        bit a_s, a_e, ok;
        lo = 0;
        hi = p.size();
        a_s = 1'b0;
        a_e = 1'b0;
        if (hi > 0 && p[0] == 8'h5E) begin a_s = 1'b1; lo = 1; end
        if (hi > lo && p[hi-1] == 8'h24) begin a_e = 1'b1; hi = hi - 1; end
        for (int pos = 0; pos < s.size(); pos++) begin
            ok = 1'b1;
            if (a_s && pos > 0 && s[pos-1] != 8'h20) ok = 1'b0;
            for (int k = lo; k < hi; k++) begin
                j = pos + k - lo;
                if (j >= s.size()) ok = 1'b0;
                else if (p[k] != 8'h2E && p[k] != s[j]) ok = 1'b0;
            end
            e = pos + hi - lo;
            if (a_e && e < s.size() && s[e] != 8'h20) ok = 1'b0;
            if (ok) return {1'b1, 5'(pos)};
        end
        return 6'd0;
    endfunction

    function automatic logic [7:0] rand_chr(input bit for_pat);
        int r;
        r = $urandom_range(0, for_pat ? 3 : 2);
        case (r)
            0:       return 8'h61;
            1:       return 8'h62;
            2:       return 8'h20;
            default: return 8'h2E;
        endcase
    endfunction

    task automatic junk_sme();
        sme_valid       = ($urandom_range(0, 3) == 0);
        sme_match       = 1'($urandom);
        sme_match_index = 5'($urandom);
    endtask

    task automatic send_byte(input logic [1:0] t, input logic [7:0] d);
        int n;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        in_valid = 1'b1;
        in_type  = t;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready: got %b required 1", in_ready);
        end
        junk_sme();
        @(negedge clk);
        in_valid = 1'b0;
        in_type  = 2'($urandom);
        in_data  = 8'($urandom);
    endtask

    task automatic send_job();
        int si, pi;
        si = 0;
        pi = 0;
        while (si < job_str.size() || pi < job_pat.size()) begin
            if (si < job_str.size() && (pi >= job_pat.size() || $urandom_range(0, 1) == 1)) begin
                send_byte(2'd0, job_str[si]);
                si++;
            end else begin
                send_byte(2'd1, job_pat[pi]);
                pi++;
            end
            if ($urandom_range(0, 7) == 0) send_byte(2'd3, 8'($urandom));
        end
        send_byte(2'd2, 8'($urandom));
        sme_valid = 1'b0;
    endtask

    // mode 0: SME answers after 'delay' WAIT cycles; 1: never answers; 2: answers on the timeout cycle
    task automatic run_job(input int mode, input int delay, input int hold);
        int s_len, p_len, exp_err, n;
        logic [5:0] mr, sr;
        logic       exp_m;
        logic [4:0] exp_i;
        bytes_t     seen_s, seen_p, use_s;
        logic [9:0] got_v, exp_v;
        logic [8:0] exp_r;

        s_len = job_str.size();
        p_len = job_pat.size();
        if (s_len > STR_MAX || p_len > PAT_MAX) exp_err = 1;
        else if (p_len == 0 || (s_len == 0 && !model_loaded)) exp_err = 2;
        else exp_err = 0;
        if (s_len > 0) use_s = job_str;
        else use_s = model_str;
        exp_m = 1'b0;
        exp_i = 5'd0;

        send_job();

        if (exp_err != 0) begin
            n_checks++;
            if ({sme_isstring, sme_ispattern, sme_chardata} !== 10'd0) begin
                n_fail++;
                $display("FAIL sme_idle_on_error: got %b%b %h required 0 0 00",
                         sme_isstring, sme_ispattern, sme_chardata);
            end
        end else begin
            for (int k = 0; k <= s_len + p_len; k++) begin
                got_v = {sme_isstring, sme_ispattern, sme_chardata};
                if (k < s_len) exp_v = {2'b10, job_str[k]};
                else if (k < s_len + p_len) exp_v = {2'b01, job_pat[k-s_len]};
                else exp_v = 10'd0;
                n_checks++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL sme_trace[%0d]: got %h required %h", k, got_v, exp_v);
                end
                if (sme_isstring) seen_s.push_back(sme_chardata);
                if (sme_ispattern) seen_p.push_back(sme_chardata);
                if (k < s_len + p_len) begin
                    junk_sme();
                    @(negedge clk);
                end
            end
            sme_valid = 1'b0;
            if (seen_s.size() > 0) sme_str = seen_s;
            sr = ref_match(sme_str, seen_p);
            mr = ref_match(use_s, job_pat);
            exp_m = mr[5];
            exp_i = mr[4:0];
            if (mode == 0) begin
                for (int k = 0; k < delay; k++) begin
                    sme_match = 1'($urandom);
                    sme_match_index = 5'($urandom);
                    @(negedge clk);
                    n_checks++;
                    if (res_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL early_result: res_valid %b required 0", res_valid);
                    end
                end
                sme_valid = 1'b1;
                sme_match = sr[5];
                sme_match_index = sr[4:0];
                @(negedge clk);
                sme_valid = 1'b0;
            end else if (mode == 1) begin
                n = 0;
                while (res_valid !== 1'b1 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                n_checks++;
                if (n != TIMEOUT + 1) begin
                    n_fail++;
                    $display("FAIL timeout_latency: got %0d cycles required %0d", n, TIMEOUT + 1);
                end
                exp_err = 3;
                exp_m = 1'b0;
                exp_i = 5'd0;
            end else begin
                repeat (TIMEOUT) @(negedge clk);
                sme_valid = 1'b1;
                sme_match = sr[5];
                sme_match_index = sr[4:0];
                @(negedge clk);
                sme_valid = 1'b0;
            end
        end

        exp_r = {1'b1, exp_m, exp_i, 2'(exp_err)};
        n_checks++;
        if ({res_valid, res_match, res_index, res_err} !== exp_r) begin
            n_fail++;
            $display("FAIL result: got v=%b m=%b i=%0d e=%0d required v=1 m=%b i=%0d e=%0d",
                     res_valid, res_match, res_index, res_err, exp_m, exp_i, exp_err);
        end
        for (int k = 0; k < hold; k++) begin
            junk_sme();
            @(negedge clk);
            n_checks++;
            if ({res_valid, res_match, res_index, res_err} !== exp_r) begin
                n_fail++;
                $display("FAIL result_hold[%0d]: got %h required %h", k,
                         {res_valid, res_match, res_index, res_err}, exp_r);
            end
        end
        sme_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_checks++;
        if ({res_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL release: got res_valid=%b in_ready=%b required 0 1", res_valid, in_ready);
        end

        if (exp_err == 0 && s_len > 0) begin
            model_str = job_str;
            model_loaded = 1'b1;
        end
        if (exp_err == 3) model_loaded = 1'b0;
        model_jobs++;
        if (exp_err == 0 && exp_m) model_matches++;
    endtask

    task automatic do_reset();
        logic [19:0] got;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        got = {in_ready, sme_isstring, sme_ispattern, sme_chardata,
               res_valid, res_match, res_index, res_err};
        n_checks++;
        if (got !== 20'h80000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 80000", got);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_loaded = 1'b0;
        model_jobs = 0;
        model_matches = 0;
    endtask

    task automatic set_job(input string s, input string p);
        job_str.delete();
        job_pat.delete();
        for (int i = 0; i < s.len(); i++) job_str.push_back(8'(s[i]));
        for (int i = 0; i < p.len(); i++) job_pat.push_back(8'(p[i]));
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic_match();
        set_job("hello world", "wor");
        run_job(0, 2, 1);
    endtask

    task automatic test_pattern_only();
        set_job("", "^wo");
        run_job(0, 0, 0);
    endtask

    task automatic test_empty_after_reset();
        do_reset();
        set_job("", "ab");
        run_job(0, 0, 0);
    endtask

    task automatic test_overflow();
        set_job("", "a");
        for (int i = 0; i < STR_MAX + 1; i++) job_str.push_back(rand_chr(1'b0));
        run_job(0, 0, 0);
        set_job("abc", "");
        for (int i = 0; i < PAT_MAX + 1; i++) job_pat.push_back(rand_chr(1'b1));
        run_job(0, 0, 0);
    endtask

    task automatic test_timeout();
        set_job("abc", "ab");
        run_job(1, 0, 0);
        set_job("", "ab");
        run_job(0, 0, 0);
        set_job("ab ba", "ba");
        run_job(2, 0, 0);
    endtask

    task automatic test_random_jobs();
        int sl, pl;
        for (int j = 0; j < 25; j++) begin
            job_str.delete();
            job_pat.delete();
            if ($urandom_range(0, 4) == 0) sl = 0;
            else sl = $urandom_range(1, STR_MAX);
            if ($urandom_range(0, 11) == 0) pl = 0;
            else pl = $urandom_range(1, PAT_MAX);
            for (int i = 0; i < sl; i++) job_str.push_back(rand_chr(1'b0));
            for (int i = 0; i < pl; i++) job_pat.push_back(rand_chr(1'b1));
            if (pl > 1 && $urandom_range(0, 4) == 0) job_pat[0] = 8'h5E;
            if (pl > 1 && $urandom_range(0, 4) == 0) job_pat[pl-1] = 8'h24;
            run_job(0, $urandom_range(0, 5), $urandom_range(0, 3));
        end
    endtask

    task automatic test_stall_reset();
        int act;
        set_job("ab ab", "ab");
        run_job(0, 1, 5);
        job_str.delete();
        for (int i = 0; i < 20; i++) job_str.push_back(rand_chr(1'b0));
        set_job("", "a");
        for (int i = 0; i < 20; i++) job_str.push_back(rand_chr(1'b0));
        send_job();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sme_isstring !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_send_str: isstring %b required 1", sme_isstring);
        end
        do_reset();
        act = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sme_isstring || sme_ispattern || res_valid) act++;
        end
        n_checks++;
        if (act != 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_abort: got %0d active cycles in_ready=%b required 0 1", act, in_ready);
        end
        set_job("", "a");
        run_job(0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_match();
        test_pattern_only();
        test_empty_after_reset();
        test_overflow();
        test_timeout();
        test_random_jobs();
`ifdef SME_FEED_STATS_EN
        n_checks++;
        if (stat_jobs !== 16'(model_jobs) || stat_matches !== 16'(model_matches)) begin
            n_fail++;
            $display("FAIL stats: got %0d/%0d required %0d/%0d",
                     stat_jobs, stat_matches, model_jobs, model_matches);
        end
`endif
        test_stall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sme_job_feeder.md
Name: sme_job_feeder

Overview:
- Upstream stage of the string-matching engine (SME).
- Accepts tagged bytes from a host over a valid/ready byte stream and buffers one job: a string of up to 32 chars and a pattern of up to 8 chars.
- Replays the job into the SME's chardata/isstring/ispattern interface with exact SME timing, then waits for SME valid.
- Returns match/match_index, or an error code, to the host over a valid/ready result handshake.

Parameters:
- STR_MAX, 32, string buffer depth in bytes; must be ≤ 32 (SME index is 5 bits).
- PAT_MAX, 8, pattern buffer depth in bytes.
- TIMEOUT, 511, maximum cycles in WAIT before a timeout error; counter is 9 bits.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  host byte valid.
- in_ready  out  1  feeder accepts a byte this cycle.
- in_type  in  2  byte tag: 0 = string char, 1 = pattern char, 2 = end-of-job (data ignored), 3 = ignored.
- in_data  in  8  byte value.
- sme_chardata  out  8  to SME chardata.
- sme_isstring  out  1  to SME isstring.
- sme_ispattern  out  1  to SME ispattern.
- sme_valid  in  1  from SME valid.
- sme_match  in  1  from SME match.
- sme_match_index  in  5  from SME match_index.
- res_valid  out  1  result available.
- res_ready  in  1  host consumes the result.
- res_match  out  1  match flag.
- res_index  out  5  match index.
- res_err  out  2  error code: 0 = ok, 1 = buffer overflow, 2 = empty pattern or no string, 3 = timeout.

Behaviour:
- Reset: all registered outputs are 0, FSM goes to LOAD, and s_cnt, p_cnt, err, str_loaded and tmo_cnt are cleared. Reset mid-job aborts the job; nothing is sent afterwards.
- Registered outputs: all outputs except in_ready are registered. in_ready = (state == LOAD) and is purely a state decode.
- LOAD state:
  - A byte is accepted when in_valid && in_ready.
  - Type 0: written to str_buf[s_cnt] and s_cnt increments. If s_cnt == STR_MAX, the byte is dropped and err = 1.
  - Type 1: the same rule applies to pat_buf, p_cnt and PAT_MAX.
  - Type 3: accepted and discarded.
  - Type 2 (end-of-job) selects the next state, in this priority order:
    - err set → RESULT, res_err = 1.
    - p_cnt == 0, or (s_cnt == 0 && !str_loaded) → RESULT, res_err = 2.
    - s_cnt > 0 → SEND_STR.
    - Otherwise → SEND_PAT; the SME reuses the previously loaded string.
- SEND_STR state:
  - One byte per cycle: sme_isstring = 1, sme_chardata = str_buf[i], for exactly s_cnt consecutive cycles.
  - Then goes straight to SEND_PAT with no gap, and sets str_loaded = 1.
- SEND_PAT state:
  - p_cnt consecutive cycles with sme_ispattern = 1, sme_chardata = pat_buf[j].
  - Then WAIT; tmo_cnt is cleared on entry.
- WAIT state:
  - sme_isstring = sme_ispattern = 0 and sme_chardata = 0; tmo_cnt increments each cycle.
  - sme_valid = 1: capture sme_match and sme_match_index into res_match and res_index, set res_err = 0, go to RESULT.
  - tmo_cnt == TIMEOUT with no sme_valid: res_match = 0, res_index = 0, res_err = 3, str_loaded = 0, go to RESULT.
  - If sme_valid arrives in the same cycle as the TIMEOUT check, the valid wins.
- RESULT state:
  - res_valid = 1 and all res_* outputs are held stable until res_ready.
  - On res_ready: res_valid = 0, s_cnt, p_cnt and err are cleared, go to LOAD.
  - RESULT always lasts at least 1 cycle. This guarantees the SME spends one idle cycle in its Output state before the next isstring/ispattern.
- Outside WAIT: sme_valid is ignored.
- Latency: end-of-job accept to first sme_* byte is 1 cycle. SME valid to res_valid is 1 cycle.
- Throughput: one job in flight at a time.

Optional Feature:
- Macro: SME_FEED_STATS_EN.
- When defined:
  - Adds outputs stat_jobs[15:0] and stat_matches[15:0], reset to 0.
  - stat_jobs increments on every RESULT→LOAD transition.
  - stat_matches increments on those transitions when res_match = 1 and res_err = 0.
  - Both counters saturate at 16'hFFFF.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- String "hello world" (11), pattern "wor", end-of-job, bench SME model → 11 isstring cycles, then 3 ispattern cycles, then idle; res_valid with res_match = 1, res_index = 6, res_err = 0.
- Second job with pattern "^wo" only (no string bytes) → SEND_STR skipped, 3 ispattern cycles; result match = 1, index = 6.
- After reset, pattern "ab" only → no SME activity; res_err = 2, res_valid within 2 cycles of end-of-job.
- 33 string bytes plus pattern "a" → 33rd byte dropped; res_err = 1; sme_isstring never asserted.
- Stub SME that never asserts valid → res_err = 3 exactly TIMEOUT+1 cycles after WAIT entry; the next pattern-only job returns res_err = 2.
- Hold res_ready = 0 for 5 cycles, then pulse reset_n low mid-SEND_STR → res_* stay stable while ready is low; after reset all outputs are 0, in_ready = 1, and no further sme_isstring.
